// File: rtl/bench_timer_bank.sv
// bench_timer_bank: bank of register-mapped benchmark timers; BENCH_TIMER_SATURATE_EN selects saturate instead of wrap
module bench_timer_bank #(
    parameter int NUM_TIMERS  = 4,
    parameter int COUNT_WIDTH = 48,
    parameter int ADDR_WIDTH  = 7,
    parameter int BASE_ADDR   = 32
) (
    input  logic                  pcieClk_in,
    input  logic                  pcieRst_n_in,
    input  logic [ADDR_WIDTH-1:0] cpuWrAddr_in,
    input  logic [31:0]           cpuWrData_in,
    input  logic                  cpuWrValid_in,
    output logic                  cpuWrReady_out,
    input  logic [ADDR_WIDTH-1:0] cpuRdAddr_in,
    input  logic                  cpuRdValid_in,
    output logic [31:0]           cpuRdData_out,
    output logic                  cpuRdReady_out,
    input  logic [NUM_TIMERS-1:0] evt_in
);
    typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_t;
    state_t state [NUM_TIMERS];
    state_t state_nxt [NUM_TIMERS];
    logic [NUM_TIMERS-1:0][COUNT_WIDTH-1:0] count;
    logic [NUM_TIMERS-1:0][COUNT_WIDTH-1:0] shadow;
    logic [NUM_TIMERS-1:0] ovf, mode, ctrl_wr, clr, start, stop, rd_lo;
    logic [31:0] rd_data;
    logic [63:0] ext;
    logic unused_bits;
    assign cpuWrReady_out = 1'b1;
    // only the low CTRL bits are defined and the shadow's low half is never read back
    assign unused_bits = ^{cpuWrData_in[31:4], shadow};
    // CTRL write decode; CLEAR masks START, stop is software STOP or an armed event
    always_comb begin
        ctrl_wr = '0;
        clr = '0;
        start = '0;
        stop = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            ctrl_wr[i] = cpuWrValid_in && cpuWrAddr_in == ADDR_WIDTH'(BASE_ADDR + 4 * i);
            clr[i] = ctrl_wr[i] && cpuWrData_in[2];
            start[i] = ctrl_wr[i] && cpuWrData_in[0] && !cpuWrData_in[2];
            stop[i] = (ctrl_wr[i] && cpuWrData_in[1]) || (mode[i] && evt_in[i]);
        end
    end
    // per-channel next state with CLEAR > START > stop priority
    always_comb begin
        state_nxt = state;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (clr[i]) state_nxt[i] = IDLE;
            else if (start[i]) state_nxt[i] = RUNNING;
            else if (state[i] == RUNNING && stop[i]) state_nxt[i] = DONE;
        end
    end
    // channel state register
    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) begin
            for (int i = 0; i < NUM_TIMERS; i++) state[i] <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end
    // counters count every RUNNING edge (stop edge included); mode latch; LO-read snapshot
    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) begin
            count <= '0;
            shadow <= '0;
            ovf <= '0;
            mode <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (ctrl_wr[i]) mode[i] <= cpuWrData_in[3];
                if (rd_lo[i]) shadow[i] <= count[i];
                if (clr[i] || start[i]) begin
                    count[i] <= '0;
                    ovf[i] <= 1'b0;
                end else if (state[i] == RUNNING) begin
                    if (&count[i]) ovf[i] <= 1'b1;
`ifdef BENCH_TIMER_SATURATE_EN
                    if (!(&count[i])) count[i] <= count[i] + COUNT_WIDTH'(1);
`else
                    count[i] <= count[i] + COUNT_WIDTH'(1);
`endif
                end
            end
        end
    end
    // read mux on pre-write state; unmapped and reserved words read 0
    always_comb begin
        rd_data = '0;
        rd_lo = '0;
        ext = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (cpuRdAddr_in == ADDR_WIDTH'(BASE_ADDR + 4 * i))
                rd_data = {28'd0, mode[i], ovf[i], state[i] == DONE, state[i] == RUNNING};
            if (cpuRdAddr_in == ADDR_WIDTH'(BASE_ADDR + 4 * i + 1)) begin
                ext = 64'(count[i]);
                rd_data = ext[31:0];
                rd_lo[i] = cpuRdValid_in;
            end
            if (cpuRdAddr_in == ADDR_WIDTH'(BASE_ADDR + 4 * i + 2)) begin
                ext = 64'(shadow[i]);
                rd_data = ext[63:32];
            end
        end
    end
    // registered read response, one cycle per request
    always_ff @(posedge pcieClk_in or negedge pcieRst_n_in) begin
        if (!pcieRst_n_in) begin
            cpuRdData_out <= '0;
            cpuRdReady_out <= 1'b0;
        end else begin
            cpuRdData_out <= cpuRdValid_in ? rd_data : '0;
            cpuRdReady_out <= cpuRdValid_in;
        end
    end
endmodule

// File: tb/tb_bench_timer_bank.sv
// tb_bench_timer_bank: directed scenarios plus randomized traffic against a transaction-level timer model
module tb_bench_timer_bank;
    localparam int NT = 4;
    localparam int CW = 40;
    localparam int BA = 32;
    logic clk = 0;
    logic rst_n = 0;
    logic [6:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic wr_valid, wr_ready, rd_valid, rd_ready;
    logic [NT-1:0] evt;
    logic [NT-1:0][CW-1:0] ovr;
    int edge_n = 0;
    int n_vec = 0;
    int n_err = 0;

    bench_timer_bank #(.NUM_TIMERS(NT), .COUNT_WIDTH(CW), .ADDR_WIDTH(7), .BASE_ADDR(BA)) dut (
        .pcieClk_in(clk), .pcieRst_n_in(rst_n),
        .cpuWrAddr_in(wr_addr), .cpuWrData_in(wr_data), .cpuWrValid_in(wr_valid), .cpuWrReady_out(wr_ready),
        .cpuRdAddr_in(rd_addr), .cpuRdValid_in(rd_valid), .cpuRdData_out(rd_data), .cpuRdReady_out(rd_ready),
        .evt_in(evt)
    );

    always #5 clk = ~clk;
    // edge index; after #1 past an edge it names the edge just taken
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int ca(input int c, input int k);
        return BA + 4 * c + k;
    endfunction

    task automatic cyc(input logic wv, input int wa, input logic [31:0] wd, input logic rv, input int ra, input logic [NT-1:0] ev);
        wr_valid = wv; wr_addr = 7'(wa); wr_data = wd; rd_valid = rv; rd_addr = 7'(ra); evt = ev;
        @(posedge clk); #1;
        wr_valid = 0; rd_valid = 0; evt = '0;
    endtask
    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int a, input logic [31:0] d);
        cyc(1, a, d, 0, 0, 0);
    endtask
    task automatic rd(input int a);
        cyc(0, 0, 0, 1, a, 0);
    endtask
    task automatic poke(input int c, input logic [CW-1:0] v);
        ovr = dut.count;
        ovr[c] = v;
        force dut.count = ovr;
        #1 release dut.count;
    endtask

    task automatic test_reset;
        wr_valid = 0; rd_valid = 0; evt = '0; wr_addr = 0; rd_addr = 0; wr_data = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL reset_rd_ready got %b exp 0", rd_ready); end
        n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        rst_n = 1;
        for (int c = 0; c < NT; c++) for (int k = 0; k < 3; k++) begin
            rd(ca(c, k));
            n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_reg ch%0d off%0d got %h exp 0", c, k, rd_data); end
        end
    endtask

    task automatic test_sw_stop;
        wr(ca(0, 0), 1);
        idle(99);
        wr(ca(0, 0), 2);
        rd(ca(0, 0)); n_vec++; if (rd_data !== 32'h2) begin n_err++; $display("FAIL sw_status got %h exp 2", rd_data); end
        rd(ca(0, 1)); n_vec++; if (rd_data !== 32'd100) begin n_err++; $display("FAIL sw_lo got %0d exp 100", rd_data); end
        rd(ca(0, 2)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL sw_hi got %h exp 0", rd_data); end
    endtask

    task automatic test_event;
        wr(ca(2, 0), 32'h9);
        idle(20);
        cyc(0, 0, 0, 0, 0, 4'b0010);
        idle(15);
        cyc(0, 0, 0, 0, 0, 4'b0100);
        cyc(0, 0, 0, 0, 0, 4'b0100);
        rd(ca(2, 0)); n_vec++; if (rd_data !== 32'hA) begin n_err++; $display("FAIL evt_status got %h exp a", rd_data); end
        rd(ca(2, 1)); n_vec++; if (rd_data !== 32'd37) begin n_err++; $display("FAIL evt_lo got %0d exp 37", rd_data); end
        rd(ca(1, 0)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL evt_idle_status got %h exp 0", rd_data); end
        rd(ca(1, 1)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL evt_idle_lo got %h exp 0", rd_data); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp_lo, exp_hi;
`ifdef BENCH_TIMER_SATURATE_EN
        exp_lo = 32'hFFFF_FFFF; exp_hi = 32'hFF;
`else
        exp_lo = 32'h1; exp_hi = 32'h0;
`endif
        wr(ca(0, 0), 4);
        wr(ca(0, 0), 1);
        poke(0, 40'hFF_FFFF_FFFE);
        idle(2);
        wr(ca(0, 0), 2);
        rd(ca(0, 0)); n_vec++; if (rd_data !== 32'h6) begin n_err++; $display("FAIL ovf_status got %h exp 6", rd_data); end
        rd(ca(0, 1)); n_vec++; if (rd_data !== exp_lo) begin n_err++; $display("FAIL ovf_lo got %h exp %h", rd_data, exp_lo); end
        rd(ca(0, 2)); n_vec++; if (rd_data !== exp_hi) begin n_err++; $display("FAIL ovf_hi got %h exp %h", rd_data, exp_hi); end
        cyc(1, ca(0, 0), 4, 1, ca(0, 0), 0);
        n_vec++; if (rd_data !== 32'h6) begin n_err++; $display("FAIL rw_same_cycle got %h exp 6", rd_data); end
        rd(ca(0, 0)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL clear_status got %h exp 0", rd_data); end
        rd(ca(0, 1)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL clear_lo got %h exp 0", rd_data); end
    endtask

    task automatic test_snapshot;
        wr(ca(3, 0), 1);
        poke(3, 40'h12_FFFF_FFFF);
        rd(ca(3, 1)); n_vec++; if (rd_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL snap_lo got %h exp ffffffff", rd_data); end
        idle(5);
        rd(ca(3, 2)); n_vec++; if (rd_data !== 32'h12) begin n_err++; $display("FAIL snap_hi got %h exp 12", rd_data); end
        rd(ca(3, 1)); n_vec++; if (rd_data !== 32'h6) begin n_err++; $display("FAIL snap_lo2 got %h exp 6", rd_data); end
        rd(ca(3, 2)); n_vec++; if (rd_data !== 32'h13) begin n_err++; $display("FAIL snap_hi2 got %h exp 13", rd_data); end
        wr(ca(3, 0), 4);
    endtask

    task automatic test_priority;
        wr(ca(1, 0), 1);
        idle(10);
        wr(ca(1, 0), 7);
        rd(ca(1, 0)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL prio7_status got %h exp 0", rd_data); end
        rd(ca(1, 1)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL prio7_lo got %h exp 0", rd_data); end
        wr(ca(1, 0), 3);
        rd(ca(1, 0)); n_vec++; if (rd_data !== 32'h1) begin n_err++; $display("FAIL prio3_status got %h exp 1", rd_data); end
        rd(ca(1, 1)); n_vec++; if (rd_data !== 32'h1) begin n_err++; $display("FAIL prio3_lo got %h exp 1", rd_data); end
        wr(ca(1, 0), 9);
        idle(3);
        cyc(1, ca(1, 0), 9, 0, 0, 4'b0010);
        rd(ca(1, 0)); n_vec++; if (rd_data !== 32'h9) begin n_err++; $display("FAIL start_vs_evt_status got %h exp 9", rd_data); end
        rd(ca(1, 1)); n_vec++; if (rd_data !== 32'h1) begin n_err++; $display("FAIL start_vs_evt_lo got %h exp 1", rd_data); end
        wr(ca(1, 0), 4);
    endtask

    task automatic test_out_of_range;
        rd(0);
        n_vec++; if ({rd_ready, rd_data} !== 33'h1_0000_0000) begin n_err++; $display("FAIL oor_low got rdy %b data %h exp rdy 1 data 0", rd_ready, rd_data); end
        rd(BA + 4 * NT);
        n_vec++; if ({rd_ready, rd_data} !== 33'h1_0000_0000) begin n_err++; $display("FAIL oor_high got rdy %b data %h exp rdy 1 data 0", rd_ready, rd_data); end
        wr(ca(0, 3), 32'hF);
        rd(ca(0, 3)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reserved got %h exp 0", rd_data); end
        rd(ca(0, 0)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reserved_wr got %h exp 0", rd_data); end
    endtask

    task automatic test_back_to_back;
        rd(ca(2, 0));
        n_vec++; if ({rd_ready, rd_data} !== 33'h1_0000_000A) begin n_err++; $display("FAIL b2b_first got rdy %b data %h exp rdy 1 data a", rd_ready, rd_data); end
        rd(ca(2, 1));
        n_vec++; if ({rd_ready, rd_data} !== 33'h1_0000_0025) begin n_err++; $display("FAIL b2b_second got rdy %b data %h exp rdy 1 data 25", rd_ready, rd_data); end
        idle(1);
        n_vec++; if (rd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_pulse got rdy %b exp 0", rd_ready); end
    endtask

    task automatic test_random;
        int st [NT];
        bit md [NT];
        longint st_e [NT], sp_e [NT], shd [NT];
        for (int c = 0; c < NT; c++) begin
            wr(ca(c, 0), 4);
            st[c] = 0; md[c] = 0; shd[c] = 0;
        end
        for (int c = 0; c < NT; c++) begin
            rd(ca(c, 1));
            n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rand_init ch%0d got %h exp 0", c, rd_data); end
        end
        for (int n = 0; n < 500; n++) begin
            longint e, cnt;
            logic wv, rv;
            logic [31:0] wd, exp_d;
            logic [3:0] d;
            logic [NT-1:0] ev;
            int wa, ra, c, k;
            e = longint'(edge_n) + 1;
            wv = $urandom_range(0, 9) < 3;
            wa = ca($urandom_range(0, NT - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            wd = $urandom;
            if (wd[2] && $urandom_range(0, 3) != 0) wd[2] = 1'b0;
            rv = $urandom_range(0, 1) == 1;
            ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, BA - 1) : ca($urandom_range(0, NT - 1), $urandom_range(0, 3));
            ev = ($urandom_range(0, 4) == 0) ? NT'($urandom) : '0;
            exp_d = 0;
            if (rv && ra >= BA && ra < BA + 4 * NT) begin
                c = (ra - BA) / 4;
                k = (ra - BA) % 4;
                cnt = (st[c] == 1) ? e - 1 - st_e[c] : (st[c] == 2) ? sp_e[c] - st_e[c] : 0;
                if (k == 0) exp_d = {28'd0, md[c], 1'b0, st[c] == 2, st[c] == 1};
                if (k == 1) begin exp_d = 32'(cnt); shd[c] = cnt; end
                if (k == 2) exp_d = 32'(shd[c] >>> 32);
            end
            cyc(wv, wa, wd, rv, ra, ev);
            if (rv) begin
                n_vec++;
                if ({rd_ready, rd_data} !== {1'b1, exp_d}) begin n_err++; $display("FAIL rand_read addr %0d at edge %0d got rdy %b data %h exp rdy 1 data %h", ra, e, rd_ready, rd_data, exp_d); end
            end
            for (int i = 0; i < NT; i++) begin
                bit w;
                w = wv && wa == ca(i, 0);
                d = w ? wd[3:0] : 4'd0;
                if (d[2]) st[i] = 0;
                else if (d[0]) begin st[i] = 1; st_e[i] = e; end
                else if (st[i] == 1 && (d[1] || (md[i] && ev[i]))) begin st[i] = 2; sp_e[i] = e; end
                if (w) md[i] = d[3];
            end
        end
    endtask

    task automatic test_reset_midcount;
        wr(ca(3, 0), 4);
        wr(ca(0, 0), 1);
        poke(3, 40'h55_0000_0000);
        idle(20);
        rd(ca(3, 1)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL pre_rst_lo got %h exp 0", rd_data); end
        rd(ca(3, 2)); n_vec++; if (rd_data !== 32'h55) begin n_err++; $display("FAIL pre_rst_hi got %h exp 55", rd_data); end
        rd(ca(0, 1));
        n_vec++; if (rd_ready !== 1'b1) begin n_err++; $display("FAIL inflight_rdy got %b exp 1", rd_ready); end
        rst_n = 0;
        #1;
        n_vec++; if ({rd_ready, rd_data} !== 33'h0) begin n_err++; $display("FAIL async_rst got rdy %b data %h exp 0 0", rd_ready, rd_data); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int c = 0; c < NT; c++) begin
            rd(ca(c, 0));
            n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL post_rst_status ch%0d got %h exp 0", c, rd_data); end
        end
        rd(ca(0, 1)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL post_rst_lo got %h exp 0", rd_data); end
        rd(ca(3, 2)); n_vec++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL post_rst_shadow got %h exp 0", rd_data); end
    endtask

    initial begin
        test_reset;
        test_sw_stop;
        test_event;
        test_overflow;
        test_snapshot;
        test_priority;
        test_out_of_range;
        test_back_to_back;
        test_random;
        test_reset_midcount;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL timeout after %0d edges", edge_n);
        $fatal(1, "timeout");
    end
endmodule
